// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Optional FETCH_COUNT_EN macro adds a handshake counter to the top.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    VALID
  } state_t;

  localparam logic [63:0] DEF_RESET_PC = 64'd0;
  localparam logic [63:0] DEF_PC_STEP  = 64'd1;

endpackage

// File: rtl/pc_register_64_bit.sv
// Program counter register: redirect load wins over increment.
// Arithmetic is modulo 2^ADDR_W.
module pc_register_64_bit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] PC_STEP =
    ADDR_W'(DEF_PC_STEP),
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_unit_64_bit.sv
// Fetch stage: drives instruction memory, hands instr to decode.
// Define FETCH_COUNT_EN to add the fetch_count output.
module fetch_unit_64_bit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter logic [ADDR_W-1:0] PC_STEP =
    ADDR_W'(DEF_PC_STEP),
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(DEF_RESET_PC)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_E,
  output logic              mem_RW,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
`ifdef FETCH_COUNT_EN
  output logic [31:0]       fetch_count,
`endif
  input  logic              instr_ready
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              accept;
  logic              capture;

  assign accept  = instr_valid && instr_ready;
  // A redirect in WAIT drops the capture, so pc must not advance.
  assign capture = (state == WAIT) && !redirect;

  pc_register_64_bit #(
    .ADDR_W   (ADDR_W),
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .inc     (capture),
    .load    (redirect),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  assign mem_address = pc;
  assign mem_RW      = 1'b0;
  assign mem_dataIn  = '0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      mem_E       <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
      state       <= en ? REQ : IDLE;
      mem_E       <= en;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            state <= REQ;
            mem_E <= 1'b1;
          end
        end
        REQ: begin
          state <= WAIT;
          mem_E <= 1'b0;
        end
        WAIT: begin
          instr       <= mem_dataOut;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          state       <= VALID;
        end
        VALID: begin
          if (accept) begin
            instr_valid <= 1'b0;
            state       <= en ? REQ : IDLE;
            mem_E       <= en;
          end
        end
        default: begin
          state <= IDLE;
          mem_E <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fetch_count <= '0;
    end else if (accept) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit_64_bit.sv
// Self-checking bench for fetch_unit_64_bit.
// Works with or without FETCH_COUNT_EN defined.
module tb_fetch_unit_64_bit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        en = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        instr_ready = 1'b0;
  logic [63:0] mem_address;
  logic        mem_E;
  logic        mem_RW;
  logic [63:0] mem_dataIn;
  logic [63:0] mem_dataOut = '0;
  logic [63:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [63:0] exp_pc = '0;
  int unsigned exp_count = 0;

  fetch_unit_64_bit dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .en          (en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_address (mem_address),
    .mem_E       (mem_E),
    .mem_RW      (mem_RW),
    .mem_dataIn  (mem_dataIn),
    .mem_dataOut (mem_dataOut),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
`ifdef FETCH_COUNT_EN
    .fetch_count (fetch_count),
`endif
    .instr_ready (instr_ready)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Memory image: addr0=0x11, addr1=0x22, else a unique pattern.
  function automatic logic [63:0] mem_val(input logic [63:0] a);
    if (a == 64'd0) return 64'h11;
    if (a == 64'd1) return 64'h22;
    return {a[31:0] ^ 32'hC0DE_0000, ~a[63:32]};
  endfunction

  // Latency-1 read; data is garbage outside the valid cycle.
  always @(posedge Clk) begin
    if (mem_E && !mem_RW)
      mem_dataOut <= mem_val(mem_address);
    else
      mem_dataOut <= {$urandom, $urandom};
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    #2;
    vectors++;
    if (instr_valid !== 1'b0 || mem_E !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl valid=%b mem_E=%b want 0/0",
               instr_valid, mem_E);
    end
    vectors++;
    if (mem_address !== 64'd0 || instr !== 64'd0 ||
        instr_pc !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_data addr=%h instr=%h pc=%h want 0",
               mem_address, instr, instr_pc);
    end
    vectors++;
    if (mem_RW !== 1'b0 || mem_dataIn !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_mem RW=%b dataIn=%h want 0/0",
               mem_RW, mem_dataIn);
    end
`ifdef FETCH_COUNT_EN
    vectors++;
    if (fetch_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_count got %0d want 0", fetch_count);
    end
`endif
    tick();
    tick();
    Rst_n = 1'b1;
    exp_pc = 64'd0;
    exp_count = 0;
  endtask

  task automatic test_stream();
    int n;
    int c_prev;
    en = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!instr_valid && n < 12) begin
        tick();
        n++;
      end
      vectors++;
      if (instr_valid !== 1'b1 || instr !== mem_val(exp_pc) ||
          instr_pc !== exp_pc) begin
        miscompares++;
        $display("FAIL stream_%0d v=%b instr=%h pc=%h want %h/%h",
                 k, instr_valid, instr, instr_pc,
                 mem_val(exp_pc), exp_pc);
      end
      if (k > 0) begin
        vectors++;
        if (cyc - c_prev != 3) begin
          miscompares++;
          $display("FAIL stream_spacing got %0d want 3",
                   cyc - c_prev);
        end
      end
      c_prev = cyc;
      tick();
      exp_pc++;
      exp_count++;
    end
  endtask

  task automatic test_stall();
    int n;
    logic [63:0] h_instr;
    logic [63:0] h_pc;
    instr_ready = 1'b0;
    n = 0;
    while (!instr_valid && n < 12) begin
      tick();
      n++;
    end
    vectors++;
    if (instr_valid !== 1'b1 || instr !== mem_val(exp_pc) ||
        instr_pc !== exp_pc) begin
      miscompares++;
      $display("FAIL stall_first instr=%h pc=%h want %h/%h",
               instr, instr_pc, mem_val(exp_pc), exp_pc);
    end
    h_instr = instr;
    h_pc = instr_pc;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (instr_valid !== 1'b1 || instr !== h_instr ||
          instr_pc !== h_pc || mem_E !== 1'b0 ||
          mem_address !== exp_pc + 64'd1) begin
        miscompares++;
        $display("FAIL stall_hold v=%b i=%h p=%h E=%b a=%h want %h",
                 instr_valid, instr, instr_pc, mem_E,
                 mem_address, exp_pc + 64'd1);
      end
    end
    instr_ready = 1'b1;
    tick();
    exp_pc++;
    exp_count++;
  endtask

  task automatic test_redirect_wait();
    int n;
    n = 0;
    while (!mem_E && n < 12) begin
      tick();
      n++;
    end
    vectors++;
    if (mem_E !== 1'b1 || mem_address !== exp_pc) begin
      miscompares++;
      $display("FAIL redir_req E=%b addr=%h want 1/%h",
               mem_E, mem_address, exp_pc);
    end
    tick();
    redirect = 1'b1;
    redirect_pc = 64'd22;
    tick();
    redirect = 1'b0;
    exp_pc = 64'd22;
    vectors++;
    if (instr_valid !== 1'b0 || mem_E !== 1'b1 ||
        mem_address !== 64'd22) begin
      miscompares++;
      $display("FAIL redir_flush v=%b E=%b addr=%h want 0/1/22",
               instr_valid, mem_E, mem_address);
    end
    n = 0;
    while (!instr_valid && n < 12) begin
      tick();
      n++;
    end
    vectors++;
    if (instr_valid !== 1'b1 || instr !== mem_val(64'd22) ||
        instr_pc !== 64'd22) begin
      miscompares++;
      $display("FAIL redir_instr instr=%h pc=%h want %h/22",
               instr, instr_pc, mem_val(64'd22));
    end
    tick();
    exp_pc++;
    exp_count++;
  endtask

  task automatic test_en_drop();
    int n;
    n = 0;
    while (!mem_E && n < 12) begin
      tick();
      n++;
    end
    en = 1'b0;
    n = 0;
    while (!instr_valid && n < 12) begin
      tick();
      n++;
    end
    vectors++;
    if (instr_valid !== 1'b1 || instr !== mem_val(exp_pc) ||
        instr_pc !== exp_pc) begin
      miscompares++;
      $display("FAIL endrop_instr v=%b instr=%h pc=%h want %h/%h",
               instr_valid, instr, instr_pc,
               mem_val(exp_pc), exp_pc);
    end
    tick();
    exp_pc++;
    exp_count++;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (mem_E !== 1'b0 || instr_valid !== 1'b0 ||
          mem_address !== exp_pc) begin
        miscompares++;
        $display("FAIL endrop_idle E=%b v=%b addr=%h want 0/0/%h",
                 mem_E, instr_valid, mem_address, exp_pc);
      end
      tick();
    end
    en = 1'b1;
    tick();
    vectors++;
    if (mem_E !== 1'b1 || mem_address !== exp_pc) begin
      miscompares++;
      $display("FAIL endrop_resume E=%b addr=%h want 1/%h",
               mem_E, mem_address, exp_pc);
    end
    n = 0;
    while (!instr_valid && n < 12) begin
      tick();
      n++;
    end
    vectors++;
    if (instr !== mem_val(exp_pc) || instr_pc !== exp_pc) begin
      miscompares++;
      $display("FAIL endrop_next instr=%h pc=%h want %h/%h",
               instr, instr_pc, mem_val(exp_pc), exp_pc);
    end
    tick();
    exp_pc++;
    exp_count++;
  endtask

  task automatic test_wrap();
    int n;
    logic [63:0] top;
    top = '1;
    redirect = 1'b1;
    redirect_pc = top;
    tick();
    redirect = 1'b0;
    exp_pc = top;
    vectors++;
    if (mem_E !== 1'b1 || mem_address !== top) begin
      miscompares++;
      $display("FAIL wrap_req E=%b addr=%h want 1/%h",
               mem_E, mem_address, top);
    end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!instr_valid && n < 12) begin
        tick();
        n++;
      end
      vectors++;
      if (instr_valid !== 1'b1 || instr !== mem_val(exp_pc) ||
          instr_pc !== exp_pc) begin
        miscompares++;
        $display("FAIL wrap_%0d instr=%h pc=%h want %h/%h",
                 k, instr, instr_pc, mem_val(exp_pc), exp_pc);
      end
      tick();
      exp_pc++;
      exp_count++;
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (!mem_E && n < 12) begin
      tick();
      n++;
    end
    tick();
    #2;
    Rst_n = 1'b0;
    #1;
    vectors++;
    if (instr_valid !== 1'b0 || mem_E !== 1'b0 ||
        mem_address !== 64'd0) begin
      miscompares++;
      $display("FAIL areset_ctl v=%b E=%b addr=%h want 0/0/0",
               instr_valid, mem_E, mem_address);
    end
    vectors++;
    if (instr !== 64'd0 || instr_pc !== 64'd0) begin
      miscompares++;
      $display("FAIL areset_data instr=%h pc=%h want 0/0",
               instr, instr_pc);
    end
`ifdef FETCH_COUNT_EN
    vectors++;
    if (fetch_count !== 32'd0) begin
      miscompares++;
      $display("FAIL areset_count got %0d want 0", fetch_count);
    end
`endif
    tick();
    Rst_n = 1'b1;
    exp_pc = 64'd0;
    exp_count = 0;
  endtask

  task automatic test_random();
    int n;
    logic        hold;
    logic [63:0] h_instr;
    logic [63:0] h_pc;
    hold = 1'b0;
    h_instr = '0;
    h_pc = '0;
    for (int k = 0; k < 600; k++) begin
      vectors++;
      if (mem_RW !== 1'b0 || mem_dataIn !== 64'd0 ||
          (mem_E && instr_valid)) begin
        miscompares++;
        $display("FAIL rnd_static RW=%b dIn=%h E=%b v=%b",
                 mem_RW, mem_dataIn, mem_E, instr_valid);
      end
      if (hold) begin
        vectors++;
        if (instr_valid !== 1'b1 || instr !== h_instr ||
            instr_pc !== h_pc) begin
          miscompares++;
          $display("FAIL rnd_hold v=%b instr=%h pc=%h want %h/%h",
                   instr_valid, instr, instr_pc, h_instr, h_pc);
        end
      end
      if (mem_E) begin
        vectors++;
        if (mem_address !== exp_pc) begin
          miscompares++;
          $display("FAIL rnd_addr got %h want %h",
                   mem_address, exp_pc);
        end
      end
      en = ($urandom % 4) != 0;
      instr_ready = ($urandom % 3) != 0;
      redirect = ($urandom % 20) == 0;
      if ($urandom % 4 == 0)
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
      else
        redirect_pc = 64'($urandom % 256);
      if (instr_valid && instr_ready) begin
        vectors++;
        if (instr !== mem_val(exp_pc) || instr_pc !== exp_pc) begin
          miscompares++;
          $display("FAIL rnd_deliver instr=%h pc=%h want %h/%h",
                   instr, instr_pc, mem_val(exp_pc), exp_pc);
        end
        exp_pc++;
        exp_count++;
      end
      hold = instr_valid && !instr_ready && !redirect;
      h_instr = instr;
      h_pc = instr_pc;
      if (redirect) exp_pc = redirect_pc;
      tick();
    end
    redirect = 1'b0;
    en = 1'b1;
    instr_ready = 1'b1;
    n = 0;
    while (!instr_valid && n < 12) begin
      tick();
      n++;
    end
    vectors++;
    if (instr_valid !== 1'b1 || instr !== mem_val(exp_pc) ||
        instr_pc !== exp_pc) begin
      miscompares++;
      $display("FAIL rnd_drain v=%b instr=%h pc=%h want %h/%h",
               instr_valid, instr, instr_pc,
               mem_val(exp_pc), exp_pc);
    end
    tick();
    exp_pc++;
    exp_count++;
`ifdef FETCH_COUNT_EN
    vectors++;
    if (fetch_count !== 32'(exp_count)) begin
      miscompares++;
      $display("FAIL rnd_count got %0d want %0d",
               fetch_count, exp_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_en_drop();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
